slave_regfile: RTL and testbench

Parametrised register-file bus slave, the successor of the fixed single-response slave. It serves reads and writes to an array of `NUM_REGS` registers, each `DATA_W` bits wide, through a valid/ready handshake. The number of wait states is programmable, and register 0 is a read-only ID. It sits on the communication bus as a standard slave endpoint alongside the other bus slaves.

---
 rtl/slave_regfile.sv | 181 ++++++++++++++++++
 tb/tb_slave_regfile.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : slave_regfile
// Description : Register-file bus slave with a valid/ready handshake and a
//               programmable number of wait states. It holds NUM_REGS
//               registers of DATA_W bits. Register 0 is a read-only ID.
//               Registers 1..NUM_REGS-1 are read/write.
//               An out-of-range read returns ERR_RDATA. An out-of-range
//               write is ignored.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous reset, active low
//               valid      - master request, held high until ready
//               read       - 1 = read, 0 = write
//               addr       - word address
//               write_data - write payload
//               ready      - one-cycle completion pulse (registered)
//               read_data  - read result, held until the next completed read
//               err        - out-of-range flag, valid while ready is high
// Options     : SLAVE_REGFILE_ERR_EN - when defined, builds the err flag.
//               When undefined, err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module slave_regfile #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 4,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hCAFEBABE,
    parameter logic [DATA_W-1:0] ERR_RDATA   = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic              ready,
    output logic [DATA_W-1:0] read_data,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DATA = 2'd3;

    // The width is one bit wider than the address, so that
    // NUM_REGS == 2**ADDR_W still fits.
    localparam logic [ADDR_W:0] c_num_regs = NUM_REGS[ADDR_W:0];
    localparam logic [3:0]      c_wait     = WAIT_STATES[3:0];
    localparam logic [3:0]      c_wait_m1  = c_wait - 4'd1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [3:0]        r_cnt;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];
    logic              r_ready;
    logic [DATA_W-1:0] r_rdata;
    logic              w_enter_data;
    logic              w_in_range;
    logic [DATA_W-1:0] w_rdata;

    // All decisions after the address phase use the captured request only.
    assign w_in_range = ({1'b0, r_addr} < c_num_regs);

    // The write commit, the read-data update and ready are all tied to the
    // edge that enters DATA.
    assign w_enter_data = (w_state_next == S_DATA) &&
                          ((r_state == S_ADDR) || (r_state == S_WAIT));

    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE: w_state_next = valid ? S_ADDR : S_IDLE;
            S_ADDR: begin
                if (!valid)
                    w_state_next = S_IDLE;
                else if (c_wait == 4'd0)
                    w_state_next = S_DATA;
                else
                    w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!valid)
                    w_state_next = S_IDLE;
                else if (r_cnt == 4'd0)
                    w_state_next = S_DATA;
                else
                    w_state_next = S_WAIT;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= 4'd0;
        else if ((r_state == S_ADDR) && (w_state_next == S_WAIT))
            r_cnt <= c_wait_m1;
        else if ((r_state == S_WAIT) && (r_cnt != 4'd0))
            r_cnt <= r_cnt - 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == S_IDLE) && valid) begin
            r_rd    <= read;
            r_addr  <= addr;
            r_wdata <= write_data;
        end
    end

    // Register 0 is not stored. The loop starts at 1, so writes to the ID
    // are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_enter_data && !r_rd) begin
            for (int i = 1; i < NUM_REGS; i++)
                if (r_addr == i[ADDR_W-1:0])
                    r_regs[i] <= r_wdata;
        end
    end

    always_comb begin
        w_rdata = ERR_RDATA;
        if (r_addr == '0) begin
            w_rdata = ID_VALUE;
        end else if (w_in_range) begin
            for (int i = 1; i < NUM_REGS; i++)
                if (r_addr == i[ADDR_W-1:0])
                    w_rdata = r_regs[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_enter_data;
            if (w_enter_data && r_rd)
                r_rdata <= w_rdata;
        end
    end

    assign ready     = r_ready;
    assign read_data = r_rdata;

`ifdef SLAVE_REGFILE_ERR_EN
    logic r_err;

    // This flag is only set on DATA entry. It clears itself on the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_err <= 1'b0;
        else
            r_err <= w_enter_data && !w_in_range;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_slave_regfile
// Description : Directed testbench for slave_regfile. It uses two
//               instances: u_dut0 with WAIT_STATES=0 and u_dut3 with
//               WAIT_STATES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_regfile;

`ifdef SLAVE_REGFILE_ERR_EN
    localparam logic c_err_en = 1'b1;
`else
    localparam logic c_err_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        v    [2];
    logic        rd   [2];
    logic [3:0]  ad   [2];
    logic [31:0] wd   [2];
    logic        rdy  [2];
    logic [31:0] rdat [2];
    logic        er   [2];

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_regs [8];

    always #5 clk = ~clk;

    slave_regfile #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .valid(v[0]), .read(rd[0]), .addr(ad[0]),
        .write_data(wd[0]), .ready(rdy[0]), .read_data(rdat[0]), .err(er[0])
    );

    slave_regfile #(.WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(reset), .valid(v[1]), .read(rd[1]), .addr(ad[1]),
        .write_data(wd[1]), .ready(rdy[1]), .read_data(rdat[1]), .err(er[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one transaction and checks the ready latency and the one-cycle
    // pulse. After capture, addr and write_data are scrambled to show that
    // only the captured values are used.
    task automatic xact(input int d, input logic r, input logic [3:0] a,
                        input logic [31:0] w, input int exp_lat, input string tag,
                        output logic [31:0] data, output logic e);
        int  n;
        bit  got;
        @(negedge clk);
        v[d] = 1'b1; rd[d] = r; ad[d] = a; wd[d] = w;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                ad[d] = ~a;
                wd[d] = ~w;
            end
            if (rdy[d]) got = 1'b1;
        end
        chk({tag, " latency"}, n, exp_lat);
        data = rdat[d];
        e    = er[d];
        v[d] = 1'b0;
        @(negedge clk);
        chk({tag, " pulse"}, {31'd0, rdy[d]}, 32'd0);
    endtask

    logic [31:0] data;
    logic        e;

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v[d] = 1'b0; rd[d] = 1'b0; ad[d] = '0; wd[d] = '0;
        end
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'd0;
        exp_regs[0] = 32'hCAFEBABE;
        repeat (3) @(negedge clk);
        chk("reset ready", {31'd0, rdy[0]}, 32'd0);
        chk("reset rdata", rdat[0], 32'd0);
        chk("reset err", {31'd0, er[0]}, 32'd0);
        reset = 1'b1;

        // WAIT_STATES=0 instance
        xact(0, 1'b1, 4'd0, 32'd0, 2, "rd id", data, e);
        chk("rd id data", data, 32'hCAFEBABE);
        chk("rd id err", {31'd0, e}, 32'd0);

        xact(0, 1'b0, 4'd3, 32'h12345678, 2, "wr r3", data, e);
        exp_regs[3] = 32'h12345678;
        chk("wr keeps rdata", data, 32'hCAFEBABE);
        chk("wr r3 err", {31'd0, e}, 32'd0);
        xact(0, 1'b1, 4'd3, 32'd0, 2, "rd r3", data, e);
        chk("rd r3 data", data, 32'h12345678);
        xact(0, 1'b1, 4'd0, 32'd0, 2, "rd id2", data, e);
        chk("rd id2 data", data, 32'hCAFEBABE);

        // An abort during ADDR must leave register 2 untouched.
        @(negedge clk);
        v[0] = 1'b1; rd[0] = 1'b0; ad[0] = 4'd2; wd[0] = 32'h55;
        @(negedge clk);
        v[0] = 1'b0;
        begin
            int seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (rdy[0]) seen++;
            end
            chk("abort no ready", seen, 0);
        end
        xact(0, 1'b1, 4'd2, 32'd0, 2, "rd r2 abort", data, e);
        chk("rd r2 after abort", data, 32'd0);

        // Fill every register with a distinct value, then read all of them back.
        for (int i = 1; i < 8; i++) begin
            logic [31:0] vv;
            vv = i;
            vv = vv * 32'h01010101 + 32'h80000000;
            exp_regs[i] = vv;
            xact(0, 1'b0, i[3:0], vv, 2, "fill", data, e);
        end
        // These writes are out of range or target the ID, so they are ignored.
        xact(0, 1'b0, 4'd12, 32'h1, 2, "wr oor", data, e);
        chk("wr oor err", {31'd0, e}, {31'd0, c_err_en});
        xact(0, 1'b0, 4'd0, 32'h1, 2, "wr id", data, e);
        for (int i = 0; i < 8; i++) begin
            xact(0, 1'b1, i[3:0], 32'd0, 2, "readback", data, e);
            chk($sformatf("readback r%0d", i), data, exp_regs[i]);
        end

        xact(0, 1'b1, 4'd9, 32'd0, 2, "rd oor", data, e);
        chk("rd oor data", data, 32'hDEADBEEF);
        chk("rd oor err", {31'd0, e}, {31'd0, c_err_en});
        @(negedge clk);
        chk("err cleared", {31'd0, er[0]}, 32'd0);
        xact(0, 1'b1, 4'd7, 32'd0, 2, "rd r7", data, e);
        chk("rd r7 err", {31'd0, e}, 32'd0);

        // WAIT_STATES=3 instance
        xact(1, 1'b0, 4'd1, 32'hA5A5A5A5, 5, "ws3 wr r1", data, e);
        xact(1, 1'b1, 4'd1, 32'd0, 5, "ws3 rd r1", data, e);
        chk("ws3 rd r1 data", data, 32'hA5A5A5A5);

        // Assert reset during WAIT of a write. The write must be dropped.
        @(negedge clk);
        v[1] = 1'b1; rd[1] = 1'b0; ad[1] = 4'd4; wd[1] = 32'hFF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst ready", {31'd0, rdy[1]}, 32'd0);
        chk("rst rdata", rdat[1], 32'd0);
        v[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post rst rdata", rdat[1], 32'd0);
        xact(1, 1'b1, 4'd4, 32'd0, 5, "ws3 rd r4", data, e);
        chk("ws3 rd r4 data", data, 32'd0);
        xact(0, 1'b1, 4'd3, 32'd0, 2, "rd r3 post rst", data, e);
        chk("r3 cleared", data, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
